// File: rtl/PECfg.sv
// PE configuration and instruction payload types shared by the PE control path.
package PECfg;

    typedef struct packed {
        logic       Xnor;
        logic [2:0] Wb;
        logic [2:0] Ab;
    } Conf;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] arg;
    } Inst;

endpackage

// File: rtl/PECtlCfg.sv
// Command-loader encodings: word types, error codes and conf-word field layout.
package PECtlCfg;

    typedef enum logic {
        CMD_CONF = 1'b0,
        CMD_INST = 1'b1
    } CmdType;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_ORDER   = 2'd2,
        ERR_RSVD    = 2'd3
    } LdErr;

    localparam int unsigned FIELD_W  = 3;
    localparam int unsigned AB_LSB   = 0;
    localparam int unsigned WB_LSB   = 3;
    localparam int unsigned XNOR_BIT = 6;
    localparam int unsigned RSVD_LSB = 7;

    // A precision field is legal only when it encodes 1, 2 or 4 bits.
    function automatic logic legal_bits(input logic [FIELD_W-1:0] f);
        return (f == 3'd1) || (f == 3'd2) || (f == 3'd4);
    endfunction

endpackage

// File: rtl/pe_inst_fifo.sv
// Flop-based instruction FIFO with registered full/empty and a saturating count.
module pe_inst_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_push = push && !full && !clear;
        do_pop  = pop && !empty && !clear;
        cnt_n   = cnt + CW'(do_push) - CW'(do_pop);
        if (clear) begin
            cnt_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= wr_ptr + PW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
            cnt   <= cnt_n;
            full  <= (cnt_n == CW'(DEPTH));
            empty <= (cnt_n == '0);
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/pe_cmd_loader.sv
// PE command front end: decodes conf words, queues instruction words and tracks sticky errors.
module pe_cmd_loader
    import PECfg::*;
    import PECtlCfg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_type,
    input  logic [DW-1:0] i_cmd_data,
    input  logic          i_ctl_idle,
    input  logic          i_clear,
    output Conf           o_PEconf,
    output logic          o_conf_valid,
    output Inst           o_PEinst,
    output logic          o_inst_valid,
    input  logic          i_inst_ready,
    output logic          o_error,
    output logic [1:0]    o_err_code
);

    localparam int unsigned CONF_W = $bits(Conf);
    localparam int unsigned INST_W = $bits(Inst);

    typedef enum logic [1:0] {
        S_NOCONF = 2'd0,
        S_RUN    = 2'd1,
        S_ERR    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    Conf               conf_q;
    Conf               conf_n;
    logic              conf_valid_q;
    logic              conf_valid_n;
    logic              error_q;
    LdErr              err_q;
    LdErr              err_n;
    LdErr              dec_err_c;
    logic              ready_c;
    logic              accept_c;
    logic              push_c;
    logic              pop_c;
    logic              is_inst_c;
    logic              fifo_full;
    logic              fifo_empty;
    logic [INST_W-1:0] fifo_head;
    logic [FIELD_W-1:0] ab_c;
    logic [FIELD_W-1:0] wb_c;
    logic              xnor_c;
    logic              rsvd_set_c;

    // Conf-word legality; reserved bits outrank field errors.
    always_comb begin
        ab_c       = i_cmd_data[AB_LSB +: FIELD_W];
        wb_c       = i_cmd_data[WB_LSB +: FIELD_W];
        xnor_c     = i_cmd_data[XNOR_BIT];
        rsvd_set_c = |i_cmd_data[DW-1:RSVD_LSB];
        dec_err_c  = ERR_NONE;
        if (rsvd_set_c) begin
            dec_err_c = ERR_RSVD;
        end else if (!legal_bits(ab_c) || !legal_bits(wb_c) ||
                     (xnor_c && ((ab_c != 3'd1) || (wb_c != 3'd1)))) begin
            dec_err_c = ERR_ILLEGAL;
        end
    end

    assign is_inst_c = (i_cmd_type == CMD_INST);

    // Ready depends only on state, FIFO flags and idle, never on i_inst_ready.
    always_comb begin
        ready_c = 1'b0;
        case (state)
            S_NOCONF: ready_c = 1'b1;
            S_RUN:    ready_c = is_inst_c ? !fifo_full : (fifo_empty && i_ctl_idle);
            default:  ready_c = 1'b0;
        endcase
    end

    assign accept_c     = i_cmd_valid && ready_c && !i_clear;
    assign o_inst_valid = !fifo_empty && (state != S_ERR);
    assign pop_c        = o_inst_valid && i_inst_ready && !i_clear;

    always_comb begin
        state_n      = state;
        conf_n       = conf_q;
        conf_valid_n = conf_valid_q;
        err_n        = err_q;
        push_c       = 1'b0;
        if (i_clear) begin
            state_n      = S_NOCONF;
            conf_valid_n = 1'b0;
            err_n        = ERR_NONE;
        end else begin
            case (state)
                S_NOCONF: begin
                    if (accept_c) begin
                        if (is_inst_c) begin
                            err_n   = ERR_ORDER;
                            state_n = S_ERR;
                        end else if (dec_err_c == ERR_NONE) begin
                            conf_n       = i_cmd_data[CONF_W-1:0];
                            conf_valid_n = 1'b1;
                            state_n      = S_RUN;
                        end else begin
                            err_n   = dec_err_c;
                            state_n = S_ERR;
                        end
                    end
                end
                S_RUN: begin
                    if (accept_c) begin
                        if (is_inst_c) begin
                            push_c = 1'b1;
                        end else if (dec_err_c == ERR_NONE) begin
                            conf_n       = i_cmd_data[CONF_W-1:0];
                            conf_valid_n = 1'b1;
                        end else begin
                            conf_valid_n = 1'b0;
                            err_n        = dec_err_c;
                            state_n      = S_ERR;
                        end
                    end
                end
                default: begin
                    state_n = S_ERR;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_NOCONF;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            conf_q       <= '0;
            conf_valid_q <= 1'b0;
            err_q        <= ERR_NONE;
            error_q      <= 1'b0;
        end else begin
            conf_q       <= conf_n;
            conf_valid_q <= conf_valid_n;
            err_q        <= err_n;
            error_q      <= (state_n == S_ERR);
        end
    end

    pe_inst_fifo #(
        .DEPTH (DEPTH),
        .W     (INST_W)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clear (i_clear),
        .push  (push_c),
        .din   (i_cmd_data[INST_W-1:0]),
        .pop   (pop_c),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_cmd_ready  = ready_c;
    assign o_PEconf     = conf_q;
    assign o_conf_valid = conf_valid_q;
    assign o_PEinst     = fifo_head;
    assign o_error      = error_q;
    assign o_err_code   = err_q;

endmodule

// File: tb/tb_pe_cmd_loader.sv
// Directed self-checking bench for pe_cmd_loader with hand-computed expectations.
module tb_pe_cmd_loader;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_type;
    logic [15:0] i_cmd_data;
    logic        i_ctl_idle;
    logic        i_clear;
    PECfg::Conf  o_PEconf;
    logic        o_conf_valid;
    PECfg::Inst  o_PEinst;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic        o_error;
    logic [1:0]  o_err_code;

    int checks = 0;
    int errors = 0;

    pe_cmd_loader #(.DW(16), .DEPTH(4)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_type   (i_cmd_type),
        .i_cmd_data   (i_cmd_data),
        .i_ctl_idle   (i_ctl_idle),
        .i_clear      (i_clear),
        .o_PEconf     (o_PEconf),
        .o_conf_valid (o_conf_valid),
        .o_PEinst     (o_PEinst),
        .o_inst_valid (o_inst_valid),
        .i_inst_ready (i_inst_ready),
        .o_error      (o_error),
        .o_err_code   (o_err_code)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    // Drive one command word until accepted (bounded); returns at edge+1 after acceptance.
    task automatic send(input logic t, input logic [15:0] d, output logic ok);
        ok          = 1'b0;
        i_cmd_valid = 1'b1;
        i_cmd_type  = t;
        i_cmd_data  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (o_cmd_ready) ok = 1'b1;
            cycle();
        end
        i_cmd_valid = 1'b0;
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        cycle();
        i_clear = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_cmd_valid = 0; i_cmd_type = 0; i_cmd_data = '0;
        i_ctl_idle = 1'b1; i_clear = 0; i_inst_ready = 0;
        #12;
        checks++;
        if (o_cmd_ready !== 1'b1 || o_conf_valid !== 1'b0 || o_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b conf_valid=%b inst_valid=%b want 1 0 0", o_cmd_ready, o_conf_valid, o_inst_valid);
        end
        checks++;
        if (o_PEconf !== 7'h00 || o_PEinst !== 12'h000 || o_error !== 1'b0 || o_err_code !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: conf=%h inst=%h err=%b code=%0d want 0 0 0 0", o_PEconf, o_PEinst, o_error, o_err_code);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_conf_load();
        logic ok;
        send(1'b0, 16'h0012, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL conf_accept: ok=%b want 1", ok); end
        checks++;
        if (o_conf_valid !== 1'b1 || o_PEconf.Ab !== 3'd2 || o_PEconf.Wb !== 3'd2 || o_PEconf.Xnor !== 1'b0) begin
            errors++;
            $display("FAIL conf_load: valid=%b Ab=%0d Wb=%0d Xnor=%b want 1 2 2 0", o_conf_valid, o_PEconf.Ab, o_PEconf.Wb, o_PEconf.Xnor);
        end
    endtask

    task automatic test_fifo_full();
        logic ok;
        logic [15:0] words [4] = '{16'h1001, 16'h2002, 16'h3003, 16'h4004};
        i_inst_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(1'b1, words[k], ok);
            checks++;
            if (ok !== 1'b1) begin errors++; $display("FAIL fifo_push%0d: ok=%b want 1", k, ok); end
        end
        i_cmd_valid = 1'b1; i_cmd_type = 1'b1; i_cmd_data = 16'hF505;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b0 || o_inst_valid !== 1'b1 || o_PEinst !== 12'h001) begin
            errors++;
            $display("FAIL fifo_full_stall: ready=%b valid=%b head=%h want 0 1 001", o_cmd_ready, o_inst_valid, o_PEinst);
        end
        cycle();
        i_inst_ready = 1'b1;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b0) begin errors++; $display("FAIL full_pop_no_push: ready=%b want 0", o_cmd_ready); end
        cycle();
        checks++;
        if (o_PEinst !== 12'h002 || o_cmd_ready !== 1'b1) begin
            errors++; $display("FAIL pop1: head=%h ready=%b want 002 1", o_PEinst, o_cmd_ready);
        end
        cycle();
        i_cmd_valid = 1'b0;
        checks++;
        if (o_PEinst !== 12'h003) begin errors++; $display("FAIL pop2: head=%h want 003", o_PEinst); end
        cycle();
        checks++;
        if (o_PEinst !== 12'h004) begin errors++; $display("FAIL pop3: head=%h want 004", o_PEinst); end
        cycle();
        checks++;
        if (o_PEinst !== 12'h505 || o_inst_valid !== 1'b1) begin
            errors++; $display("FAIL pop4: head=%h valid=%b want 505 1", o_PEinst, o_inst_valid);
        end
        cycle();
        i_inst_ready = 1'b0;
        checks++;
        if (o_inst_valid !== 1'b0) begin errors++; $display("FAIL drained: valid=%b want 0", o_inst_valid); end
    endtask

    task automatic test_conf_blocked();
        logic ok;
        send(1'b1, 16'h0077, ok);
        i_cmd_valid = 1'b1; i_cmd_type = 1'b0; i_cmd_data = 16'h0024;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b0) begin errors++; $display("FAIL conf_block_nonempty: ready=%b want 0", o_cmd_ready); end
        i_inst_ready = 1'b1;
        cycle();
        i_inst_ready = 1'b0;
        i_ctl_idle   = 1'b0;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b0 || o_PEconf !== 7'h12) begin
            errors++; $display("FAIL conf_block_busy: ready=%b conf=%h want 0 12", o_cmd_ready, o_PEconf);
        end
        cycle();
        i_ctl_idle = 1'b1;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL conf_unblock: ready=%b want 1", o_cmd_ready); end
        cycle();
        i_cmd_valid = 1'b0;
        checks++;
        if (o_PEconf !== 7'h24 || o_conf_valid !== 1'b1) begin
            errors++; $display("FAIL conf_reload: conf=%h valid=%b want 24 1", o_PEconf, o_conf_valid);
        end
    endtask

    task automatic test_clear_push();
        logic ok;
        send(1'b1, 16'h0011, ok);
        send(1'b1, 16'h0022, ok);
        i_cmd_valid = 1'b1; i_cmd_type = 1'b1; i_cmd_data = 16'h0033;
        i_clear = 1'b1;
        cycle();
        i_clear = 1'b0; i_cmd_valid = 1'b0;
        checks++;
        if (o_inst_valid !== 1'b0 || o_conf_valid !== 1'b0 || o_error !== 1'b0 || o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_push: ivalid=%b cvalid=%b err=%b ready=%b want 0 0 0 1", o_inst_valid, o_conf_valid, o_error, o_cmd_ready);
        end
        cycle();
        checks++;
        if (o_inst_valid !== 1'b0) begin errors++; $display("FAIL clear_no_push: ivalid=%b want 0", o_inst_valid); end
    endtask

    task automatic test_inst_before_conf();
        logic ok;
        send(1'b1, 16'h0005, ok);
        checks++;
        if (ok !== 1'b1 || o_error !== 1'b1 || o_err_code !== 2'd2) begin
            errors++; $display("FAIL inst_first: ok=%b err=%b code=%0d want 1 1 2", ok, o_error, o_err_code);
        end
        i_cmd_valid = 1'b1; i_cmd_type = 1'b0; i_cmd_data = 16'h0012;
        cycle();
        checks++;
        if (o_cmd_ready !== 1'b0 || o_inst_valid !== 1'b0 || o_conf_valid !== 1'b0) begin
            errors++; $display("FAIL err_hold: ready=%b ivalid=%b cvalid=%b want 0 0 0", o_cmd_ready, o_inst_valid, o_conf_valid);
        end
        i_cmd_valid = 1'b0;
        do_clear();
        checks++;
        if (o_error !== 1'b0 || o_err_code !== 2'd0 || o_cmd_ready !== 1'b1) begin
            errors++; $display("FAIL err_clear: err=%b code=%0d ready=%b want 0 0 1", o_error, o_err_code, o_cmd_ready);
        end
    endtask

    task automatic test_illegal_conf();
        logic ok;
        logic [15:0] words [2]  = '{16'h0043, 16'h0091};
        logic [1:0]  codes [2]  = '{2'd1, 2'd3};
        for (int k = 0; k < 2; k++) begin
            send(1'b0, words[k], ok);
            checks++;
            if (o_error !== 1'b1 || o_err_code !== codes[k] || o_conf_valid !== 1'b0 || o_cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL illegal_%h: err=%b code=%0d cvalid=%b ready=%b want 1 %0d 0 0", words[k], o_error, o_err_code, o_conf_valid, o_cmd_ready, codes[k]);
            end
            do_clear();
        end
        send(1'b0, 16'h0009, ok);
        send(1'b0, 16'h0044, ok);
        checks++;
        if (o_err_code !== 2'd1 || o_conf_valid !== 1'b0 || o_PEconf !== 7'h09) begin
            errors++; $display("FAIL run_illegal: code=%0d cvalid=%b conf=%h want 1 0 09", o_err_code, o_conf_valid, o_PEconf);
        end
        do_clear();
        send(1'b0, 16'h0183, ok);
        checks++;
        if (o_err_code !== 2'd3) begin errors++; $display("FAIL err_precedence: code=%0d want 3", o_err_code); end
        do_clear();
    endtask

    task automatic test_async_reset();
        logic ok;
        send(1'b0, 16'h0012, ok);
        send(1'b1, 16'h0abc, ok);
        send(1'b1, 16'h0def, ok);
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b1 || o_conf_valid !== 1'b0 || o_PEconf !== 7'h00 || o_PEinst !== 12'h000 ||
            o_inst_valid !== 1'b0 || o_error !== 1'b0 || o_err_code !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: ready=%b cvalid=%b conf=%h inst=%h ivalid=%b err=%b code=%0d want 1 0 00 000 0 0 0",
                     o_cmd_ready, o_conf_valid, o_PEconf, o_PEinst, o_inst_valid, o_error, o_err_code);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        test_reset();
        test_conf_load();
        test_fifo_full();
        test_conf_blocked();
        test_clear_push();
        test_inst_before_conf();
        test_illegal_conf();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_cmd_loader.md
# pe_cmd_loader

Command front end of the PE. Accepts a word stream from the array-level distributor over a valid/ready handshake, decodes configuration words into the `PECfg::Conf` register, and buffers instruction words in a small FIFO. It presents `i_PEconf` and `i_PEinst` to the downstream `DataPathController`, using a valid/ready issue handshake. It rejects illegal configurations and out-of-order commands, and reports them through a sticky error state.

## Interface
Parameters:
- `DW`, 16, command word width; must be ≥ `$bits(PECfg::Conf)` and ≥ `$bits(PECfg::Inst)`.
- `DEPTH`, 4, instruction FIFO depth; must be a power of two, ≥ 2.

Ports:
- `i_clk`  in  1  single clock; all state is on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_cmd_valid`  in  1  command word valid.
- `o_cmd_ready`  out  1  command word accepted when valid && ready.
- `i_cmd_type`  in  1  0 = configuration word, 1 = instruction word.
- `i_cmd_data`  in  DW  command payload.
- `i_ctl_idle`  in  1  controller is in IDLE with no work in flight.
- `i_clear`  in  1  synchronous flush of configuration, FIFO and error state.
- `o_PEconf`  out  `PECfg::Conf`  active configuration.
- `o_conf_valid`  out  1  `o_PEconf` holds a legal, loaded configuration.
- `o_PEinst`  out  `PECfg::Inst`  FIFO head instruction.
- `o_inst_valid`  out  1  head instruction valid.
- `i_inst_ready`  in  1  controller takes head; a pop occurs when valid && ready.
- `o_error`  out  1  sticky error flag.
- `o_err_code`  out  2  error cause: 0 none, 1 illegal conf, 2 inst before conf, 3 reserved bits set.

## Operation
Configuration word layout:
- [2:0] `Ab`, [5:3] `Wb`, [6] `Xnor`, [DW-1:7] reserved.
- `Ab` and `Wb` must each be one of {1, 2, 4}.
- If `Xnor` = 1, both `Ab` and `Wb` must equal 1.
- Reserved bits must be 0.

Instruction word: bits [$bits(Inst)-1:0] are stored verbatim. Upper bits are ignored.

FSM states:
- **S_NOCONF** (reset state).
  - `o_cmd_ready` = 1.
  - Legal conf word: load conf, go to S_RUN.
  - Illegal conf word: error code 1 or 3, go to S_ERR.
  - Instruction word: consumed, error code 2, go to S_ERR.
- **S_RUN**.
  - Instruction word: ready = !full. The word is pushed on acceptance.
  - Conf word: ready = empty && `i_ctl_idle` && !`o_inst_valid`. A legal word reloads conf and the state stays S_RUN. An illegal word goes to S_ERR; the old conf is kept but `o_conf_valid` drops.
- **S_ERR**.
  - `o_cmd_ready` = 0, `o_inst_valid` = 0, `o_error` = 1.
  - FIFO contents are frozen.
  - Only `i_clear` exits, to S_NOCONF.

Priority and boundary rules:
- `i_clear` has priority over every accept and pop in the same cycle. It empties the FIFO, deasserts `o_conf_valid`, clears `o_error` and `o_err_code`, and goes to S_NOCONF.
- `o_cmd_ready` never depends combinationally on `i_inst_ready`. A full FIFO refuses a push even if a pop happens in the same cycle.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits and saturates at exactly DEPTH.
- Error precedence when several apply: code 3 over code 1.

## Timing
- Reset values of all outputs: `o_cmd_ready` = 1, `o_conf_valid` = 0, `o_PEconf` = 0, `o_PEinst` = 0, `o_inst_valid` = 0, `o_error` = 0, `o_err_code` = 0.
- Conf accepted in cycle N: `o_PEconf` and `o_conf_valid` update in cycle N+1.
- Instruction accepted into an empty FIFO in cycle N: `o_inst_valid` = 1 in cycle N+1. There is no bypass.
- `o_PEinst` and `o_inst_valid` are registered or driven from flop outputs only, and stay stable until popped.
- After a pop in cycle N, the next head appears in cycle N+1.
- `o_error` rises in the cycle after the offending accept.
- Reset asserted mid-operation: all state returns to its reset value immediately. In-flight instructions are lost.

## Structure
- Additions to package `PECtlCfg`:
  - `CmdType` enum (`CMD_CONF`, `CMD_INST`).
  - `LdErr` enum (codes 0–3).
  - Localparams for conf-word field offsets.
  - A `legal_bits` function.
- One sub-module, `pe_inst_fifo`: parameterised DEPTH, width `$bits(PECfg::Inst)`, flop-based, with registered full/empty. The FSM, decode and error logic stay in `pe_cmd_loader`.

## Test plan
- Reset, then conf 0x0012 (Ab=2, Wb=2): `o_conf_valid` = 1 in the next cycle; `o_PEconf.Ab` = 2, `o_PEconf.Wb` = 2.
- Push 5 instructions with `i_inst_ready` = 0 and DEPTH = 4: the 4th is accepted and the 5th stalls (ready = 0). Raise ready: the heads pop in order, and the 5th is then accepted.
- Instruction word before any conf: consumed; `o_error` = 1 and code = 2 the next cycle; `o_cmd_ready` = 0 until `i_clear`.
- Conf 0x0043 (Xnor=1, Ab=3): code 1. Conf 0x0091 (reserved bit 7 set): code 3. Both lead to S_ERR.
- Conf word while the FIFO is non-empty or `i_ctl_idle` = 0: `o_cmd_ready` = 0 and conf is unchanged. It is accepted one cycle after the FIFO is empty and `i_ctl_idle` = 1.
- `i_clear` in the same cycle as a valid push with 2 entries held: FIFO empty, no push, `o_conf_valid` = 0 in the next cycle. Async reset mid-burst: all outputs at reset values immediately.
